alu_share_sched: RTL and testbench

- Time-shares one two-stage chained ALU pipeline between NREQ requesters: z = alu(op2, alu(op1, a, b), c).
- Arbitration is round-robin with a valid/grant handshake.
- Results return tagged with the requester index.
- Includes a drain state machine so software or a parent controller can quiesce the pipeline before reconfiguration or clock switching.
- Replaces per-lane duplicated ALUs where throughput allows.

---
 rtl/alu_share_sched.sv | 126 ++++++++++++
 tb/tb_alu_share_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin time-shared two-stage chained ALU, z = alu(op2, alu(op1, a, b), c)
// Ports: clk/rst_n (sync active-low reset); req/a/b/c/op1/op2 flattened per requester (slice i = requester i);
//   gnt one-hot grant (combinational); z/z_valid/z_id tagged result; drain/drain_done quiesce handshake; busy.
// Optional build macro ALU_SCHED_STATS_EN adds acc_cnt/stall_cnt saturating counters.
// `N and `OPN normally come from malu.vh; the guarded defaults below keep this file self-contained.
`ifndef N
`define N 8
`endif
`ifndef OPN
`define OPN 3
`endif
module alu_share_sched #(
  parameter int NREQ = 2,
  parameter int IDW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*`N-1:0]    a,
  input  logic [NREQ*`N-1:0]    b,
  input  logic [NREQ*`N-1:0]    c,
  input  logic [NREQ*`OPN-1:0]  op1,
  input  logic [NREQ*`OPN-1:0]  op2,
  output logic [NREQ-1:0]       gnt,
  output logic [`N-1:0]         z,
  output logic                  z_valid,
  output logic [IDW-1:0]        z_id,
  input  logic                  drain,
  output logic                  drain_done,
  output logic                  busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]           acc_cnt,
  output logic [15:0]           stall_cnt
`endif
);
  localparam logic [`OPN-1:0] ALU_ADD = 0, ALU_SUB = 1, ALU_AND = 2, ALU_OR = 3, ALU_XOR = 4;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  function automatic logic [`N-1:0] alu(input logic [`OPN-1:0] op, input logic [`N-1:0] x, input logic [`N-1:0] y);
    case (op)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      default: return x;
    endcase
  endfunction
  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, gid, id_s1_q, id_s1_d, z_id_q, z_id_d;
  logic           found, acc, s1_v_q, s1_v_d, z_valid_q, z_valid_d, drain_done_q, drain_done_d;
  logic [`N-1:0]  q_q, q_d, c_s1_q, c_s1_d, z_q, z_d;
  logic [`OPN-1:0] op2_s1_q, op2_s1_d;
  always_comb begin
    found = 1'b0;
    gid = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req[(int'(rr_q) + k) % NREQ]) begin
        found = 1'b1;
        gid = IDW'((int'(rr_q) + k) % NREQ);
      end
    gnt = (state_q == RUN && !drain && found) ? NREQ'(1) << gid : '0;
    acc = |(req & gnt);
    rr_d = !acc ? rr_q : (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
    s1_v_d = acc;
    q_d = acc ? alu(op1[gid*`OPN +: `OPN], a[gid*`N +: `N], b[gid*`N +: `N]) : q_q;
    c_s1_d = acc ? c[gid*`N +: `N] : c_s1_q;
    op2_s1_d = acc ? op2[gid*`OPN +: `OPN] : op2_s1_q;
    id_s1_d = acc ? gid : id_s1_q;
    z_valid_d = s1_v_q;
    z_d = s1_v_q ? alu(op2_s1_q, q_q, c_s1_q) : z_q;
    z_id_d = s1_v_q ? id_s1_q : z_id_q;
    // Empty check uses registered valids, so DRAIN always lasts at least one cycle.
    state_d = (state_q == RUN) ? (drain ? DRAIN : RUN) :
              (state_q == DRAIN) ? (!drain ? RUN : (!s1_v_q && !z_valid_q) ? DONE : DRAIN) :
              (drain ? DONE : RUN);
    drain_done_d = state_d == DONE;
  end
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] acc_cnt_q, acc_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        done_entry;
  always_comb begin
    done_entry = state_d == DONE && state_q != DONE;
    acc_cnt_d = done_entry ? '0 : (acc && acc_cnt_q != 16'hFFFF) ? acc_cnt_q + 1'b1 : acc_cnt_q;
    stall_cnt_d = done_entry ? '0 : (|req && !acc && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    acc_cnt_q <= !rst_n ? '0 : acc_cnt_d;
    stall_cnt_q <= !rst_n ? '0 : stall_cnt_d;
  end
  assign acc_cnt = acc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      rr_q <= '0;
      s1_v_q <= 1'b0;
      z_valid_q <= 1'b0;
      z_q <= '0;
      z_id_q <= '0;
      drain_done_q <= 1'b0;
      q_q <= '0;
      c_s1_q <= '0;
      op2_s1_q <= '0;
      id_s1_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      s1_v_q <= s1_v_d;
      z_valid_q <= z_valid_d;
      z_q <= z_d;
      z_id_q <= z_id_d;
      drain_done_q <= drain_done_d;
      q_q <= q_d;
      c_s1_q <= c_s1_d;
      op2_s1_q <= op2_s1_d;
      id_s1_q <= id_s1_d;
    end
  end
  assign z = z_q;
  assign z_valid = z_valid_q;
  assign z_id = z_id_q;
  assign drain_done = drain_done_q;
  assign busy = s1_v_q | z_valid_q;
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: scoreboard bench for alu_share_sched (NREQ=2, 8-bit data, 3-bit opcodes)
module tb_alu_share_sched;
  localparam logic [2:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4;
  typedef struct {logic [7:0] z; logic id; int due;} exp_t;
  logic        clk = 0, rst_n = 0, drain = 0;
  logic [1:0]  req = 0, gnt;
  logic [15:0] a = 0, b = 0, c = 0;
  logic [5:0]  op1 = 0, op2 = 0;
  logic [7:0]  z;
  logic        z_valid, z_id, drain_done, busy;
  int          checks = 0, failures = 0, cyc = 0, dcyc, n;
  exp_t        sb[$];
  exp_t        e;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] acc_cnt, stall_cnt;
`endif
  alu_share_sched #(.NREQ(2), .IDW(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .op1(op1), .op2(op2),
    .gnt(gnt), .z(z), .z_valid(z_valid), .z_id(z_id), .drain(drain),
    .drain_done(drain_done), .busy(busy)
`ifdef ALU_SCHED_STATS_EN
    , .acc_cnt(acc_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("result_missing_due", 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end
    if (z_valid) begin
      if (sb.size() == 0) chk("unexpected_z_valid", 32'(z_valid), 0);
      else begin
        e = sb.pop_front();
        chk("z", 32'(z), 32'(e.z));
        chk("z_id", 32'(z_id), 32'(e.id));
        chk("z_latency", 32'(cyc), 32'(e.due));
      end
    end
  end
  task automatic set_op(input int i, input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv,
                        input logic [2:0] o1, input logic [2:0] o2);
    a[i*8 +: 8] = av;
    b[i*8 +: 8] = bv;
    c[i*8 +: 8] = cv;
    op1[i*3 +: 3] = o1;
    op2[i*3 +: 3] = o2;
  endtask
  task automatic step(input logic [1:0] eg, input logic [7:0] ez);
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    if (eg != 0) sb.push_back('{ez, eg[1], cyc + 2});
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!drain_done && n < 12);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_z_valid", 32'(z_valid), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_z_id", 32'(z_id), 0);
    chk("rst_drain_done", 32'(drain_done), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    set_op(0, 3, 4, 5, ADD, ADD);
    req = 2'b01;
    step(2'b01, 8'd12);
    req = 0;
    repeat (3) step(2'b00, 0);
    set_op(0, 10, 3, 2, SUB, ADD);
    set_op(1, 8'h0F, 8'h3C, 8'hFF, AND_, XOR_);
    req = 2'b11;
    step(2'b10, 8'hF3);
    step(2'b01, 8'h09);
    step(2'b10, 8'hF3);
    step(2'b01, 8'h09);
    req = 0;
    repeat (2) step(2'b00, 0);
    req = 2'b01;
    for (int i = 0; i < 8; i++) begin
      set_op(0, 8'(i), 10, 8'h80, ADD, OR_);
      step(2'b01, 8'h8A + 8'(i));
    end
    req = 0;
    repeat (3) step(2'b00, 0);
    req = 2'b01;
    set_op(0, 1, 1, 1, ADD, SUB);
    step(2'b01, 8'd1);
    set_op(0, 200, 100, 44, ADD, ADD);
    step(2'b01, 8'd88);
    drain = 1;
    step(2'b00, 0);
    dcyc = cyc - 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("gnt_drain", 32'(gnt), 0);
      chk("busy_drain", 32'(busy), 32'(cyc <= dcyc + 1));
    end while (!drain_done && n < 12);
    chk("drain_done_time", 32'(cyc), 32'(dcyc + 3));
`ifdef ALU_SCHED_STATS_EN
    chk("acc_cnt_clear", 32'(acc_cnt), 0);
    chk("stall_cnt_clear", 32'(stall_cnt), 0);
`endif
    @(posedge clk);
    #1;
    drain = 0;
    set_op(0, 7, 7, 7, XOR_, OR_);
    step(2'b00, 0);
    @(negedge clk);
    chk("drain_done_drop", 32'(drain_done), 0);
    chk("gnt_after_drain", 32'(gnt), 2'b01);
    sb.push_back('{8'd7, 1'b0, cyc + 2});
    @(posedge clk);
    #1;
    req = 0;
    repeat (3) step(2'b00, 0);
    set_op(0, 3, 4, 5, ADD, ADD);
    req = 2'b01;
    @(negedge clk);
    chk("gnt_killed_op", 32'(gnt), 2'b01);
    @(posedge clk);
    #1;
    req = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_z_valid", 32'(z_valid), 0);
    chk("mid_rst_z", 32'(z), 0);
    chk("mid_rst_z_id", 32'(z_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_drain_done", 32'(drain_done), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    set_op(1, 5, 9, 3, OR_, SUB);
    req = 2'b11;
    step(2'b01, 8'd12);
    step(2'b10, 8'd10);
    req = 2'b01;
    step(2'b01, 8'd12);
    drain = 1;
    step(2'b00, 0);
    step(2'b00, 0);
    req = 0;
`ifdef ALU_SCHED_STATS_EN
    @(negedge clk);
    chk("acc_cnt", 32'(acc_cnt), 3);
    chk("stall_cnt", 32'(stall_cnt), 2);
`endif
    wait_done();
    chk("drain_done_2", 32'(drain_done), 1);
`ifdef ALU_SCHED_STATS_EN
    chk("acc_cnt_after_drain", 32'(acc_cnt), 0);
    chk("stall_cnt_after_drain", 32'(stall_cnt), 0);
`endif
    @(posedge clk);
    #1;
    drain = 0;
    repeat (4) step(2'b00, 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
